// File: rtl/sort_stream_io.sv
// Stream front-end for an external sort engine: loads a batch into sort memory,
// hands the memory to the sort controller, then streams the sorted words out.
// Define SORT_STREAM_IO_DESC_EN to unload in descending address order.
module sort_stream_io #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 8,
    localparam int unsigned AW    = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              mem_own,
    output logic              mem_we,
    output logic [AW-1:0]     mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              sort_s,
    input  logic              sort_done,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
    output logic              busy
);

    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_LOAD,
        S_START,
        S_WAIT,
        S_RADDR,
        S_RDATA,
        S_OUT
    } state_t;

    state_t            state;
    state_t            state_nx;
    logic [AW-1:0]     wcnt;
    logic [AW-1:0]     rcnt;
    logic [AW-1:0]     raddr;
    logic [DATA_W-1:0] data_q;
    logic              wr_fire;
    logic              rd_fire;

`ifdef SORT_STREAM_IO_DESC_EN
    assign raddr = LAST - rcnt;
`else
    assign raddr = rcnt;
`endif

    assign out_data = data_q;
    assign busy     = (state != S_LOAD);

    // State, counters and output word register
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_LOAD;
            wcnt   <= '0;
            rcnt   <= '0;
            data_q <= '0;
        end else begin
            state <= state_nx;
            if (wr_fire) begin
                wcnt <= (wcnt == LAST) ? '0 : wcnt + AW'(1);
            end
            if (state == S_RDATA) begin
                data_q <= mem_rdata;
            end
            if (rd_fire) begin
                rcnt <= (rcnt == LAST) ? '0 : rcnt + AW'(1);
            end
        end
    end

    // Next-state and port decode; sort_s is masked by rst so it drops immediately
    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        mem_own   = 1'b1;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        sort_s    = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        wr_fire   = 1'b0;
        rd_fire   = 1'b0;
        case (state)
            S_LOAD: begin
                in_ready = 1'b1;
                mem_addr = wcnt;
                if (in_valid) begin
                    wr_fire   = 1'b1;
                    mem_we    = 1'b1;
                    mem_wdata = in_data;
                    if (wcnt == LAST) begin
                        state_nx = S_START;
                    end
                end
            end
            S_START: begin
                mem_own  = 1'b0;
                sort_s   = ~rst;
                state_nx = S_WAIT;
            end
            S_WAIT: begin
                mem_own = 1'b0;
                sort_s  = ~rst;
                if (sort_done) begin
                    state_nx = S_RADDR;
                end
            end
            S_RADDR: begin
                mem_addr = raddr;
                state_nx = S_RDATA;
            end
            S_RDATA: begin
                mem_addr = raddr;
                state_nx = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_last  = (rcnt == LAST);
                if (out_ready) begin
                    rd_fire  = 1'b1;
                    state_nx = (rcnt == LAST) ? S_LOAD : S_RADDR;
                end
            end
            default: begin
                state_nx = S_LOAD;
            end
        endcase
    end

endmodule

// File: doc/sort_stream_io.md
SORT_STREAM_IO -- requirements
Module: sort_stream_io

Interface
REQ-001 Parameter DATA_W, default 8, word width of sorted elements.
REQ-002 Parameter DEPTH, default 8, number of elements per sort batch (>=2); AW = $clog2(DEPTH).
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 in_valid  in  1  input word present; in_data in DATA_W input word; in_ready out 1 block accepts word.
REQ-007 mem_own  out  1  1 = this block drives sort memory port; 0 = sort controller owns it.
REQ-008 mem_we out 1, mem_addr out AW, mem_wdata out DATA_W  memory write/read port.
REQ-009 mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_addr is presented.
REQ-010 sort_s  out  1  start/hold level to sort controller; sort_done  in  1  sort controller done.
REQ-011 out_valid out 1, out_data out DATA_W, out_last out 1; out_ready in 1  sorted output stream.
REQ-012 busy  out  1  high in any state other than LOAD.

Function
REQ-013 States: LOAD, START, WAIT, RADDR, RDATA, OUT.
REQ-014 LOAD: in_ready=1, mem_own=1; on in_valid&in_ready write in_data to mem_addr=wcnt (mem_we=1 same cycle), wcnt++.
REQ-015 Write of word index DEPTH-1 SHALL move LOAD->START next cycle; wcnt clears to 0; in_ready=0 outside LOAD.
REQ-016 START: mem_own=0, sort_s=1; unconditionally ->WAIT next cycle.
REQ-017 WAIT: sort_s=1, mem_own=0; hold until sort_done=1, then ->RADDR with sort_s=0 from that next cycle (sort controller released back to its idle state).
REQ-018 sort_done=1 observed in LOAD/START SHALL be ignored; sort_s SHALL never be high outside START/WAIT.
REQ-019 RADDR: mem_own=1, mem_we=0, mem_addr=rcnt; ->RDATA next cycle.
REQ-020 RDATA: capture mem_rdata into output register; ->OUT.
REQ-021 OUT: out_valid=1, out_data=captured word, out_last=1 iff final index; out_data stable while out_valid&~out_ready.
REQ-022 OUT on out_ready: if final index ->LOAD (rcnt cleared), else rcnt advances, ->RADDR.
REQ-023 Throughput in unload: one word per 3 cycles with out_ready held high; first out_valid 2 cycles after leaving WAIT.
REQ-024 Counters wcnt/rcnt are AW bits; they SHALL never exceed DEPTH-1 (explicit compare, no reliance on wrap when DEPTH not power of 2).
REQ-025 in_valid while in_ready=0 SHALL have no effect; data is not buffered.
REQ-026 mem_we SHALL be 0 whenever mem_own=0; mem_addr/mem_wdata SHALL be 0 when mem_own=0.

Reset
REQ-027 On rst=1 at clk edge: state=LOAD, wcnt=rcnt=0, output register=0.
REQ-028 Reset values: in_ready=1 (first cycle after reset), mem_own=1, mem_we=0, sort_s=0, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-029 Reset mid-batch (any state) SHALL abandon the batch; partially loaded memory content is don't-care; sort_s drops in the same cycle reset is sampled.

Configuration
REQ-030 Macro SORT_STREAM_IO_DESC_EN: defined -> unload reads addresses DEPTH-1 down to 0 (reversed order, out_last on address 0); undefined -> unload reads 0 up to DEPTH-1 (out_last on DEPTH-1). Load order unaffected.

Verification
REQ-031 Load 8,3,5,1,7,2,6,4 back-to-back -> mem writes addr 0..7 in 8 cycles, START one cycle after 8th write, sort_s=1.
REQ-032 In WAIT hold sort_done=0 for 20 cycles then 1 -> sort_s stays 1 for exactly those cycles, falls next cycle, state RADDR.
REQ-033 Sorted memory 1..8, out_ready=1, macro undefined -> out_data 1,2,...,8 every 3 cycles, out_last only with 8, then in_ready=1.
REQ-034 Same with SORT_STREAM_IO_DESC_EN -> out_data 8,7,...,1, out_last with 1.
REQ-035 out_ready low 5 cycles on word 3 -> out_valid held, out_data unchanged, no rcnt advance.
REQ-036 rst=1 during WAIT and during OUT -> next cycle sort_s=0, out_valid=0, in_ready=1, new batch loads from addr 0.
